// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, addresses instruction memory and
// loads the IF/ID register, honouring hazard stalls/flushes and execute redirects.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_f,
  input  logic        stall_d,
  input  logic        flush_d,
  input  logic        pc_src_e,
  input  logic [31:0] pc_target_e,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic [31:0] pc_f,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc_plus4_d,
  output logic        valid_d,
  output logic        misalign_d,
  output logic [31:0] fetch_count
);

  typedef enum logic {BOOT, RUN} state_t;

  state_t      state_q;
  state_t      state_nxt;
  logic        run;
  logic        capture;
  logic        misalign_hit;
  logic [31:0] pc_plus4_f;
  logic [31:0] pc_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= BOOT;
    else        state_q <= state_nxt;
  end

  // BOOT exists only to give one quiet cycle after reset release.
  always_comb begin
    state_nxt = state_q;
    run       = 1'b0;
    case (state_q)
      BOOT:    state_nxt = RUN;
      RUN:     run = 1'b1;
      default: state_nxt = BOOT;
    endcase
  end

  assign imem_addr    = pc_f;
  assign pc_plus4_f   = pc_f + 32'd4;
  assign capture      = run && !flush_d && !stall_d;
  assign misalign_hit = run && pc_src_e && (pc_target_e[1:0] != 2'b00);

  // Redirect beats stall; a redirect target is always forced to a word boundary.
  always_comb begin
    pc_nxt = pc_f;
    if (run) begin
      if (pc_src_e)     pc_nxt = {pc_target_e[31:2], 2'b00};
      else if (!stall_f) pc_nxt = pc_plus4_f;
    end
  end

  // ---- IF stage: program counter ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_f       <= RESET_PC;
      misalign_d <= 1'b0;
    end else begin
      pc_f <= pc_nxt;
      if (misalign_hit) misalign_d <= 1'b1;
    end
  end

  // ---- IF/ID boundary ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_d     <= NOP_INSTR;
      pc_d        <= 32'd0;
      pc_plus4_d  <= 32'd0;
      valid_d     <= 1'b0;
      fetch_count <= 32'd0;
    end else if (run) begin
      if (flush_d) begin
        instr_d    <= NOP_INSTR;
        pc_d       <= 32'd0;
        pc_plus4_d <= 32'd0;
        valid_d    <= 1'b0;
      end else if (capture) begin
        instr_d     <= imem_instr;
        pc_d        <= pc_f;
        pc_plus4_d  <= pc_plus4_f;
        valid_d     <= 1'b1;
        fetch_count <= fetch_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboard bench for if_fetch_stage: a driver updates a behavioural model per edge
// and queues the expected state; a monitor compares DUT outputs after each edge/reset.
module tb_if_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall_f = 1'b0, stall_d = 1'b0, flush_d = 1'b0, pc_src_e = 1'b0;
  logic [31:0] pc_target_e = 32'd0;
  logic [31:0] imem_addr, imem_instr, pc_f, instr_d, pc_d, pc_plus4_d, fetch_count;
  logic        valid_d, misalign_d;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[31:16] ^ 16'h1F00};
  endfunction

  assign imem_instr = mem_word(imem_addr);

  if_fetch_stage #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst_n(rst_n), .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d),
    .pc_src_e(pc_src_e), .pc_target_e(pc_target_e), .imem_addr(imem_addr),
    .imem_instr(imem_instr), .pc_f(pc_f), .instr_d(instr_d), .pc_d(pc_d),
    .pc_plus4_d(pc_plus4_d), .valid_d(valid_d), .misalign_d(misalign_d),
    .fetch_count(fetch_count)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pcd;
    logic [31:0] pc4;
    logic        vld;
    logic        mis;
    logic [31:0] cnt;
  } exp_t;

  exp_t q[$];
  exp_t m;
  bit   m_booted;

  task automatic model_reset();
    m.pc = RST_PC; m.instr = NOP; m.pcd = 0; m.pc4 = 0;
    m.vld = 0; m.mis = 0; m.cnt = 0;
    m_booted = 0;
  endtask

  // Architectural effect of one rising edge with the inputs currently applied.
  task automatic model_edge();
    logic [31:0] cur;
    cur = m.pc;
    if (!rst_n) model_reset();
    else if (!m_booted) m_booted = 1;
    else begin
      if (flush_d) begin
        m.instr = NOP; m.pcd = 0; m.pc4 = 0; m.vld = 0;
      end else if (!stall_d) begin
        m.instr = mem_word(cur); m.pcd = cur; m.pc4 = cur + 4; m.vld = 1; m.cnt = m.cnt + 1;
      end
      if (pc_src_e) begin
        m.pc = pc_target_e & 32'hFFFF_FFFC;
        if (pc_target_e[1:0] != 2'b00) m.mis = 1;
      end else if (!stall_f) m.pc = cur + 4;
    end
    q.push_back(m);
  endtask

  task automatic cycle(input logic sf, input logic sd, input logic fl,
                       input logic src, input logic [31:0] tgt);
    stall_f = sf; stall_d = sd; flush_d = fl; pc_src_e = src; pc_target_e = tgt;
    model_edge();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every edge and every reset assertion presents a new output state.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk or negedge rst_n);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("pc_f", pc_f, e.pc);
        chk("imem_addr", imem_addr, e.pc);
        chk("instr_d", instr_d, e.instr);
        chk("pc_d", pc_d, e.pcd);
        chk("pc_plus4_d", pc_plus4_d, e.pc4);
        chk("valid_d", {31'd0, valid_d}, {31'd0, e.vld});
        chk("misalign_d", {31'd0, misalign_d}, {31'd0, e.mis});
        chk("fetch_count", fetch_count, e.cnt);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic sf, sd, fl, src;
    logic [31:0] tgt;
    model_reset();
    cycle(0, 0, 0, 0, 0);               // reset held through first edge
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 0);  // BOOT then free-run
    cycle(1, 1, 0, 0, 0);               // stall both
    cycle(1, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 1, 1, 32'h40);          // taken branch with flush
    cycle(0, 0, 0, 0, 0);
    cycle(1, 0, 0, 1, 32'h80);          // redirect beats stall_f
    cycle(0, 1, 1, 0, 0);               // flush beats stall_d
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 1, 1, 32'h0000_0106);   // misaligned target
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 1, 1, 32'h0000_0200);   // sticky flag survives aligned redirect
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 1, 1, 32'hFFFF_FFFC);   // wrap across 2^32
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 0);
    for (int i = 0; i < 300; i++) begin
      sf  = ($urandom_range(0, 3) == 0);
      sd  = ($urandom_range(0, 3) == 0);
      src = ($urandom_range(0, 5) == 0);
      fl  = src | ($urandom_range(0, 7) == 0);
      tgt = $urandom;
      if ($urandom_range(0, 7) != 0) tgt[1:0] = 2'b00;
      cycle(sf, sd, fl, src, tgt);
    end
    // Asynchronous reset in the middle of the high phase.
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    model_reset();
    q.push_back(m);
    @(negedge clk);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 60; i++) begin
      sf  = ($urandom_range(0, 3) == 0);
      sd  = ($urandom_range(0, 3) == 0);
      src = ($urandom_range(0, 5) == 0);
      fl  = src | ($urandom_range(0, 7) == 0);
      tgt = $urandom & 32'hFFFF_FFFC;
      cycle(sf, sd, fl, src, tgt);
    end
    @(posedge clk);
    #3;
    chk("scoreboard_drain", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
